eje3_keypad_front: RTL



---
 rtl/eje3_pkg.sv | 21 ++
 rtl/eje3_sync2.sv | 27 ++
 rtl/eje3_keypad_front.sv | 119 +++++++++++
 3 files changed

// File: rtl/eje3_pkg.sv
// Shared types and helpers for the keypad front end.
// Key count, FSM state encoding and the one-hot test.
package eje3_pkg;

  localparam int NKEYS = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  function automatic logic is_onehot10(
    input logic [NKEYS-1:0] v
  );
    return (v != '0) &&
           ((v & (v - NKEYS'(1))) == '0);
  endfunction

endpackage

// File: rtl/eje3_sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
// No logic between the stages.
module eje3_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/eje3_keypad_front.sv
// Keypad front end: sync, debounce and single-key validation.
// Presents a held one-hot key code to the BCD encoder.
module eje3_keypad_front
  import eje3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NKEYS-1:0] key_in,
  output logic [NKEYS-1:0] e_out,
  output logic             key_valid,
  output logic             key_held,
  output logic             key_err
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NKEYS-1:0] sync;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NKEYS-1:0] cand_q, cand_d;
  logic [NKEYS-1:0] e_out_q, e_out_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  eje3_sync2 #(
    .W (NKEYS)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_in),
    .q     (sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      e_out_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      e_out_q <= e_out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    e_out_d = e_out_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_onehot10(sync)) begin
          cand_d  = sync;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end else if (sync != '0) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      DEBOUNCE: begin
        if (sync != cand_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          e_out_d = cand_q;
          valid_d = 1'b1;
          state_d = PRESSED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (sync != cand_q) begin
          // Release or any change of key both need a clean release
          err_d   = (sync != '0);
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (sync != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign e_out     = e_out_q;
  assign key_valid = valid_q;
  assign key_err   = err_q;
  assign key_held  = (state_q == PRESSED);

endmodule
